// File: rtl/planning_multi_pkg.sv
// Shared definitions for the planning_multi block.
//   dir_e       : one-hot-free encoding of the single robot step taken per cycle
//   grid_max()  : last valid coordinate of the 3K x 3K grid
//   wall_lo/hi(): x coordinates of the two wall segments (x=K for y<2K, x=2K for y>=2K)
package planning_multi_pkg;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_DOWN  = 3'd1,
      DIR_UP    = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_e;

   localparam int K_DEF = 2;

   function automatic int grid_max(input int k);
      return 3 * k - 1;
   endfunction

   // Lower wall sits between columns K-1 and K; upper wall between 2K-1 and 2K.
   function automatic int wall_lo(input int k);
      return k;
   endfunction

   function automatic int wall_hi(input int k);
      return 2 * k;
   endfunction

endpackage

// File: rtl/rt_event_counter.sv
// Wrapping event counter with one tapped bit.
//   clk, rst_n : clock, async active-low reset (state -> 0)
//   inc        : count enable; state holds when low
//   tap        : bit TAP of the current state
// Sequence: 0,1,..,CNT_WRAP,0,...
module rt_event_counter #(
   parameter int CNT_W    = 11,
   parameter int CNT_WRAP = 32,
   parameter int TAP      = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   output logic tap
);

   logic [CNT_W-1:0] state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= '0;
      else if (inc)
         state <= (state < CNT_W'(CNT_WRAP)) ? state + CNT_W'(1) : '0;
   end

   assign tap = state[TAP];

endmodule

// File: rtl/planning_multi.sv
// Robot / obstacle grid monitor.
//   clk, rst_n               : clock, async active-low reset
//   move_robot               : robot move request
//   controllable_{up,down,left,right} : robot direction selects
//   move_obs_{up,down,left,right}[N_OBS] : per-obstacle direction requests
//   _rt_robot, _rt_obs       : event fired this cycle (combinational)
//   error                    : sticky, set by a collision while exclusivity holds
//   excl                     : sticky, at most one event per cycle so far
//   collide                  : robot shares a cell with some obstacle
// The robot cannot cross the wall segments; obstacles can go anywhere but are
// frozen while their maintenance bit is set. The robot is frozen by shock.
module planning_multi
   import planning_multi_pkg::*;
#(
   parameter int K         = 2,
   parameter int N_OBS     = 2,
   parameter int COORD_W   = 4,
   parameter int CNT_W     = 11,
   parameter int CNT_WRAP  = 32,
   parameter int MAINT_BIT = 2,
   parameter int SHOCK_BIT = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             move_robot,
   input  logic             controllable_up,
   input  logic             controllable_down,
   input  logic             controllable_left,
   input  logic             controllable_right,
   input  logic [N_OBS-1:0] move_obs_up,
   input  logic [N_OBS-1:0] move_obs_down,
   input  logic [N_OBS-1:0] move_obs_left,
   input  logic [N_OBS-1:0] move_obs_right,
   output logic             _rt_robot,
   output logic [N_OBS-1:0] _rt_obs,
   output logic             error,
   output logic             excl,
   output logic             collide
);

   localparam logic [COORD_W-1:0] MAXC   = COORD_W'(grid_max(K));
   localparam logic [COORD_W-1:0] WLO    = COORD_W'(wall_lo(K));
   localparam logic [COORD_W-1:0] WHI    = COORD_W'(wall_hi(K));
   localparam logic [COORD_W-1:0] WLO_M1 = COORD_W'(wall_lo(K) - 1);
   localparam logic [COORD_W-1:0] WHI_M1 = COORD_W'(wall_hi(K) - 1);
   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

   logic                            notfirst;
   logic                            live;
   logic                            cur_excl;
   logic                            shock;
   logic [N_OBS-1:0]                maint;
   logic [N_OBS:0]                  ev;

   logic [COORD_W-1:0]              robot_x, robot_y, robot_nx, robot_ny;
   logic [N_OBS-1:0][COORD_W-1:0]   obs_x, obs_y, obs_nx, obs_ny;

   logic                            can_dn, can_up, can_lf, can_rt;
   dir_e                            dir;

   // ---------------- events ----------------
   assign live      = notfirst & ~error;
   assign _rt_robot = live & move_robot;
   assign _rt_obs   = {N_OBS{live}} &
                      (move_obs_up | move_obs_down | move_obs_left | move_obs_right);
   // At most one bit set <=> clearing the lowest set bit leaves zero.
   assign ev        = {_rt_robot, _rt_obs};
   assign cur_excl  = ((ev & (ev - 1'b1)) == '0);

   always_comb begin
      collide = 1'b0;
      for (int i = 0; i < N_OBS; i++)
         if (robot_x == obs_x[i] && robot_y == obs_y[i]) collide = 1'b1;
   end

   // ---------------- robot step ----------------
   always_comb begin
      can_dn = (robot_y != '0);
      can_up = (robot_y != MAXC);
      can_lf = (robot_x != '0) &&
               !(robot_x == WLO && robot_y <  WHI) &&
               !(robot_x == WHI && robot_y >= WHI);
      can_rt = (robot_x != MAXC) &&
               !(robot_x == WLO_M1 && robot_y <  WHI) &&
               !(robot_x == WHI_M1 && robot_y >= WHI);

      // First requested direction that is not blocked wins.
      dir = DIR_NONE;
      if (_rt_robot && !shock) begin
         if      (controllable_down  && can_dn) dir = DIR_DOWN;
         else if (controllable_up    && can_up) dir = DIR_UP;
         else if (controllable_left  && can_lf) dir = DIR_LEFT;
         else if (controllable_right && can_rt) dir = DIR_RIGHT;
      end

      robot_nx = robot_x;
      robot_ny = robot_y;
      case (dir)
         DIR_DOWN:  robot_ny = robot_y - ONE;
         DIR_UP:    robot_ny = robot_y + ONE;
         DIR_LEFT:  robot_nx = robot_x - ONE;
         DIR_RIGHT: robot_nx = robot_x + ONE;
         default:   ;
      endcase
   end

   // ---------------- obstacle steps ----------------
   // Vertical and horizontal axes move independently, each saturating.
   always_comb begin
      obs_nx = obs_x;
      obs_ny = obs_y;
      for (int i = 0; i < N_OBS; i++) begin
         if (_rt_obs[i] && !maint[i]) begin
            if (move_obs_up[i]) begin
               if (obs_y[i] != MAXC) obs_ny[i] = obs_y[i] + ONE;
            end else if (move_obs_down[i]) begin
               if (obs_y[i] != '0) obs_ny[i] = obs_y[i] - ONE;
            end
            if (move_obs_left[i]) begin
               if (obs_x[i] != '0) obs_nx[i] = obs_x[i] - ONE;
            end else if (move_obs_right[i]) begin
               if (obs_x[i] != MAXC) obs_nx[i] = obs_x[i] + ONE;
            end
         end
      end
   end

   // ---------------- event counters ----------------
   for (genvar i = 0; i < N_OBS; i++) begin : g_maint
      rt_event_counter #(.CNT_W(CNT_W), .CNT_WRAP(CNT_WRAP), .TAP(MAINT_BIT)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (_rt_obs[i]),
         .tap   (maint[i])
      );
   end

   rt_event_counter #(.CNT_W(CNT_W), .CNT_WRAP(CNT_WRAP), .TAP(SHOCK_BIT)) u_shock (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (|_rt_obs),
      .tap   (shock)
   );

   // ---------------- state ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         notfirst <= 1'b0;
         excl     <= 1'b0;
         error    <= 1'b0;
         robot_x  <= '0;
         robot_y  <= '0;
         obs_x    <= '0;
         obs_y    <= '0;
      end else if (!notfirst) begin
         // Initial placement; no moves on this edge.
         notfirst <= 1'b1;
         excl     <= 1'b1;
         for (int i = 0; i < N_OBS; i++) begin
            obs_x[i] <= COORD_W'((2 + 2 * i) % (3 * K));
            obs_y[i] <= '0;
         end
      end else begin
         excl    <= excl & cur_excl;
         error   <= error | (excl & cur_excl & collide);
         robot_x <= robot_nx;
         robot_y <= robot_ny;
         obs_x   <= obs_nx;
         obs_y   <= obs_ny;
      end
   end

endmodule

// File: tb/tb_planning_multi.sv
// Directed bench for planning_multi with K=2, N_OBS=2 (6x6 grid).
module tb_planning_multi;

   logic       clk, rst_n;
   logic       move_robot, c_up, c_down, c_left, c_right;
   logic [1:0] o_up, o_down, o_left, o_right;
   logic       rt_robot;
   logic [1:0] rt_obs;
   logic       error, excl, collide;

   int n_cmp = 0;
   int n_bad = 0;

   planning_multi #(.K(2), .N_OBS(2), .COORD_W(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .move_robot         (move_robot),
      .controllable_up    (c_up),
      .controllable_down  (c_down),
      .controllable_left  (c_left),
      .controllable_right (c_right),
      .move_obs_up        (o_up),
      .move_obs_down      (o_down),
      .move_obs_left      (o_left),
      .move_obs_right     (o_right),
      ._rt_robot          (rt_robot),
      ._rt_obs            (rt_obs),
      .error              (error),
      .excl               (excl),
      .collide            (collide)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic idle();
      move_robot = 0; c_up = 0; c_down = 0; c_left = 0; c_right = 0;
      o_up = 0; o_down = 0; o_left = 0; o_right = 0;
   endtask

   // One rising edge; return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic robot_go(input logic u, d, l, r);
      idle();
      move_robot = 1; c_up = u; c_down = d; c_left = l; c_right = r;
      step();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      move_robot = 1; o_up = 2'b11;
      step(); step();
      #1;
      n_cmp++; if (rt_robot !== 1'b0) begin n_bad++; $display("FAIL rst_rt_robot: got %b want 0", rt_robot); end
      n_cmp++; if (rt_obs !== 2'b00) begin n_bad++; $display("FAIL rst_rt_obs: got %b want 00", rt_obs); end
      n_cmp++; if (excl !== 1'b0) begin n_bad++; $display("FAIL rst_excl: got %b want 0", excl); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
      n_cmp++; if (collide !== 1'b1) begin n_bad++; $display("FAIL rst_collide: got %b want 1", collide); end
      idle();
   endtask

   // Release reset between edges with requests active; first edge only places.
   task automatic test_first_edge(input string tag);
      @(negedge clk);
      rst_n = 1;
      move_robot = 1; c_right = 1; o_up = 2'b11; o_left = 2'b01;
      #1;
      n_cmp++; if (rt_robot !== 1'b0) begin n_bad++; $display("FAIL %s_rt_robot0: got %b want 0", tag, rt_robot); end
      n_cmp++; if (rt_obs !== 2'b00) begin n_bad++; $display("FAIL %s_rt_obs0: got %b want 00", tag, rt_obs); end
      step();
      idle();
      #1;
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h00) begin n_bad++; $display("FAIL %s_robot: got %h want 00", tag, {dut.robot_x, dut.robot_y}); end
      n_cmp++; if ({dut.obs_x[0], dut.obs_y[0]} !== 8'h20) begin n_bad++; $display("FAIL %s_obs0: got %h want 20", tag, {dut.obs_x[0], dut.obs_y[0]}); end
      n_cmp++; if ({dut.obs_x[1], dut.obs_y[1]} !== 8'h40) begin n_bad++; $display("FAIL %s_obs1: got %h want 40", tag, {dut.obs_x[1], dut.obs_y[1]}); end
      n_cmp++; if (excl !== 1'b1) begin n_bad++; $display("FAIL %s_excl: got %b want 1", tag, excl); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL %s_error: got %b want 0", tag, error); end
      n_cmp++; if (collide !== 1'b0) begin n_bad++; $display("FAIL %s_collide: got %b want 0", tag, collide); end
   endtask

   task automatic test_robot_walls();
      move_robot = 1; c_right = 1;
      #1;
      n_cmp++; if (rt_robot !== 1'b1) begin n_bad++; $display("FAIL rt_robot_live: got %b want 1", rt_robot); end
      idle();
      robot_go(0, 0, 0, 1);   // (0,0) -> (1,0)
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h10) begin n_bad++; $display("FAIL right_open: got %h want 10", {dut.robot_x, dut.robot_y}); end
      robot_go(0, 0, 0, 1);   // lower wall blocks
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h10) begin n_bad++; $display("FAIL right_wall: got %h want 10", {dut.robot_x, dut.robot_y}); end
      robot_go(1, 1, 0, 0);   // down blocked at y=0, falls through to up
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h11) begin n_bad++; $display("FAIL fallthru: got %h want 11", {dut.robot_x, dut.robot_y}); end
      for (int k = 0; k < 3; k++) robot_go(1, 0, 0, 0);
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h14) begin n_bad++; $display("FAIL up3: got %h want 14", {dut.robot_x, dut.robot_y}); end
      robot_go(0, 0, 0, 1);   // above lower wall: passes
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h24) begin n_bad++; $display("FAIL right_gap: got %h want 24", {dut.robot_x, dut.robot_y}); end
      robot_go(1, 0, 1, 0);   // up beats left
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h25) begin n_bad++; $display("FAIL up_left: got %h want 25", {dut.robot_x, dut.robot_y}); end
      n_cmp++; if (excl !== 1'b1) begin n_bad++; $display("FAIL walls_excl: got %b want 1", excl); end
   endtask

   task automatic test_obs_maint();
      for (int k = 0; k < 4; k++) begin idle(); o_right = 2'b01; step(); end
      idle();
      n_cmp++; if (dut.obs_x[0] !== 4'd5) begin n_bad++; $display("FAIL obs_sat: got %0d want 5", dut.obs_x[0]); end
      o_left = 2'b01; step(); idle();   // 5th: counter=4, frozen
      n_cmp++; if (dut.obs_x[0] !== 4'd5) begin n_bad++; $display("FAIL maint_5th: got %0d want 5", dut.obs_x[0]); end
      for (int k = 0; k < 3; k++) begin o_left = 2'b01; step(); end
      idle();
      n_cmp++; if (dut.obs_x[0] !== 4'd5) begin n_bad++; $display("FAIL maint_8th: got %0d want 5", dut.obs_x[0]); end
      o_left = 2'b01; step(); idle();   // 9th: counter=8, resumes
      n_cmp++; if (dut.obs_x[0] !== 4'd4) begin n_bad++; $display("FAIL maint_9th: got %0d want 4", dut.obs_x[0]); end
      for (int k = 0; k < 2; k++) begin o_left = 2'b01; step(); end
      idle();
      n_cmp++; if ({dut.obs_x[0], dut.obs_y[0]} !== 8'h20) begin n_bad++; $display("FAIL obs0_park: got %h want 20", {dut.obs_x[0], dut.obs_y[0]}); end
   endtask

   task automatic test_collision();
      for (int k = 0; k < 4; k++) robot_go(0, 1, 0, 0);
      n_cmp++; if (collide !== 1'b0) begin n_bad++; $display("FAIL pre_collide: got %b want 0", collide); end
      robot_go(0, 1, 0, 0);   // (2,1) -> (2,0) onto obs0
      n_cmp++; if (collide !== 1'b1) begin n_bad++; $display("FAIL collide: got %b want 1", collide); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL error_late: got %b want 0", error); end
      step();
      n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL error_set: got %b want 1", error); end
      move_robot = 1; c_up = 1; o_up = 2'b11;
      #1;
      n_cmp++; if (rt_robot !== 1'b0) begin n_bad++; $display("FAIL err_rt_robot: got %b want 0", rt_robot); end
      n_cmp++; if (rt_obs !== 2'b00) begin n_bad++; $display("FAIL err_rt_obs: got %b want 00", rt_obs); end
      step();
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h20) begin n_bad++; $display("FAIL err_frz_robot: got %h want 20", {dut.robot_x, dut.robot_y}); end
      n_cmp++; if ({dut.obs_x[1], dut.obs_y[1]} !== 8'h40) begin n_bad++; $display("FAIL err_frz_obs1: got %h want 40", {dut.obs_x[1], dut.obs_y[1]}); end
      n_cmp++; if (rt_robot !== 1'b0) begin n_bad++; $display("FAIL err_rt_stay: got %b want 0", rt_robot); end
   endtask

   task automatic test_reset_mid();
      idle();
      #2;
      rst_n = 0;
      #1;
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL mid_error: got %b want 0", error); end
      n_cmp++; if (excl !== 1'b0) begin n_bad++; $display("FAIL mid_excl: got %b want 0", excl); end
      n_cmp++; if (collide !== 1'b1) begin n_bad++; $display("FAIL mid_collide: got %b want 1", collide); end
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h00) begin n_bad++; $display("FAIL mid_robot: got %h want 00", {dut.robot_x, dut.robot_y}); end
      step();
      test_first_edge("rerun");
   endtask

   task automatic test_excl();
      move_robot = 1; c_right = 1; o_up = 2'b10;
      #1;
      n_cmp++; if (rt_robot !== 1'b1) begin n_bad++; $display("FAIL dual_rt_robot: got %b want 1", rt_robot); end
      n_cmp++; if (rt_obs !== 2'b10) begin n_bad++; $display("FAIL dual_rt_obs: got %b want 10", rt_obs); end
      step(); idle();
      n_cmp++; if (excl !== 1'b0) begin n_bad++; $display("FAIL dual_excl: got %b want 0", excl); end
      n_cmp++; if ({dut.robot_x, dut.robot_y} !== 8'h10) begin n_bad++; $display("FAIL dual_robot: got %h want 10", {dut.robot_x, dut.robot_y}); end
      n_cmp++; if ({dut.obs_x[1], dut.obs_y[1]} !== 8'h41) begin n_bad++; $display("FAIL dual_obs1: got %h want 41", {dut.obs_x[1], dut.obs_y[1]}); end
      o_left = 2'b01; step(); idle();   // obs0 (2,0) -> (1,0), onto robot
      n_cmp++; if (collide !== 1'b1) begin n_bad++; $display("FAIL nx_collide: got %b want 1", collide); end
      step(); step();
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL nx_error: got %b want 0", error); end
      move_robot = 1;
      #1;
      n_cmp++; if (rt_robot !== 1'b1) begin n_bad++; $display("FAIL nx_rt_robot: got %b want 1", rt_robot); end
      idle();
   endtask

   initial begin
      test_reset();
      test_first_edge("first");
      test_robot_walls();
      test_obs_maint();
      test_collision();
      test_reset_mid();
      test_excl();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
